// File: rtl/gray_conv_pipe.sv
// Purpose : streaming Gray<->binary converter; each word picks its own direction via s_mode.
// Latency : STAGES cycles from accept to m_valid; one word per cycle sustained.
// Backpr. : bubble-collapsing valid/ready chain; s_ready drops only when every stage is full and m_ready=0.
//
// Optional build macro: GRAY_SEQ_CHECK_EN
//   Adds output seq_err. It flags Gray-to-binary input words whose Hamming
//   distance from the previous Gray-to-binary input is not exactly one.
//   Without the macro the port and its registers do not exist.

module gray_conv_pipe #(
    parameter int WIDTH  = 4,   // 2..64
    parameter int STAGES = 2    // 1..8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_mode,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_mode
`ifdef GRAY_SEQ_CHECK_EN
    ,
    output logic             seq_err
`endif
);

    // ------------------------------------------------------------------
    // Conversion helpers (pure combinational, evaluated on s_data)
    // ------------------------------------------------------------------

    // Gray-to-binary: prefix XOR running from the MSB downwards.
    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b            = '0;
        b[WIDTH-1]   = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Binary-to-Gray: each bit XOR its upper neighbour; MSB passes through.
    function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] g;
        g          = '0;
        g[WIDTH-1] = b[WIDTH-1];
        for (int i = 0; i < WIDTH - 1; i++) begin
            g[i] = b[i] ^ b[i+1];
        end
        return g;
    endfunction

    // ------------------------------------------------------------------
    // Pipeline state: stage 0 is the input side, stage STAGES-1 drives m_*
    // ------------------------------------------------------------------
    logic [STAGES-1:0]            vld_q,  vld_d;
    logic [STAGES-1:0]            mode_q, mode_d;
    logic [STAGES-1:0][WIDTH-1:0] data_q, data_d;

    logic [STAGES-1:0] ld;        // stage k captures its upstream this cycle
    logic [WIDTH-1:0]  conv_dat;  // converted s_data, ready to enter stage 0
    logic              accept;    // upstream transfer happens on this edge

    // Load enables: stage k may load if the output is being drained or if any
    // stage at or after k is empty (that hole absorbs the shift). Written in
    // closed form so no bit of ld depends on another bit of ld.
    always_comb begin
        ld = '0;
        for (int k = 0; k < STAGES; k++) begin
            ld[k] = m_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!vld_q[j]) begin
                    ld[k] = 1'b1;
                end
            end
        end
    end

    // Select the conversion direction for the incoming word.
    always_comb begin
        conv_dat = '0;
        if (s_mode) begin
            conv_dat = bin_to_gray(s_data);
        end else begin
            conv_dat = gray_to_bin(s_data);
        end
    end

    assign s_ready = ld[0];
    assign accept  = s_valid && ld[0];

`ifdef GRAY_SEQ_CHECK_EN
    // ------------------------------------------------------------------
    // Gray sequence checker: compares each accepted Gray input against the
    // previous accepted Gray input. Binary-to-Gray words are ignored.
    // ------------------------------------------------------------------
    logic [STAGES-1:0] err_q, err_d;
    logic [WIDTH-1:0]  prev_q, prev_d;
    logic              have_prev_q, have_prev_d;
    logic [WIDTH-1:0]  diff;
    logic              one_bit;
    logic              new_err;

    // Exactly-one-bit test: non-zero and clearing the lowest set bit gives zero.
    always_comb begin
        diff    = s_data ^ prev_q;
        one_bit = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
        new_err = !s_mode && have_prev_q && !one_bit;
    end

    // Track the last accepted Gray-to-binary word.
    always_comb begin
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        if (accept && !s_mode) begin
            prev_d      = s_data;
            have_prev_d = 1'b1;
        end
    end

    // Reference register for the sequence check.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q      <= '0;
            have_prev_q <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
        end
    end
`endif

    // Next-state for every stage: shift on load, hold otherwise. Payload only
    // moves with a valid word so an emptied output keeps its last value.
    always_comb begin
        vld_d  = vld_q;
        mode_d = mode_q;
        data_d = data_q;
`ifdef GRAY_SEQ_CHECK_EN
        err_d  = err_q;
`endif
        if (ld[0]) begin
            vld_d[0] = s_valid;
            if (s_valid) begin
                data_d[0] = conv_dat;
                mode_d[0] = s_mode;
`ifdef GRAY_SEQ_CHECK_EN
                err_d[0]  = new_err;
`endif
            end
        end
        for (int k = 1; k < STAGES; k++) begin
            if (ld[k]) begin
                vld_d[k] = vld_q[k-1];
                if (vld_q[k-1]) begin
                    data_d[k] = data_q[k-1];
                    mode_d[k] = mode_q[k-1];
`ifdef GRAY_SEQ_CHECK_EN
                    err_d[k]  = err_q[k-1];
`endif
                end
            end
        end
    end

    // Stage registers; reset drops every in-flight word and zeroes payload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= '0;
            mode_q <= '0;
            data_q <= '0;
`ifdef GRAY_SEQ_CHECK_EN
            err_q  <= '0;
`endif
        end else begin
            vld_q  <= vld_d;
            mode_q <= mode_d;
            data_q <= data_d;
`ifdef GRAY_SEQ_CHECK_EN
            err_q  <= err_d;
`endif
        end
    end

    assign m_valid = vld_q[STAGES-1];
    assign m_data  = data_q[STAGES-1];
    assign m_mode  = mode_q[STAGES-1];
`ifdef GRAY_SEQ_CHECK_EN
    assign seq_err = err_q[STAGES-1];
`endif

endmodule

// File: tb/tb_gray_conv_pipe.sv
// Bench for gray_conv_pipe: a 4-bit/2-stage and a 16-bit/3-stage instance,
// driven from one stimulus path and checked against an arithmetic model.
// Handles the GRAY_SEQ_CHECK_EN build when the macro is defined.

module tb_gray_conv_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n   = 1'b0;
    logic        sel     = 1'b0;   // 0: 4-bit DUT, 1: 16-bit DUT
    logic        s_valid = 1'b0;
    logic        s_mode  = 1'b0;
    logic [15:0] s_data  = '0;
    logic        m_ready = 1'b0;

    logic        a_s_ready, a_m_valid, a_m_mode;
    logic [3:0]  a_m_data;
    logic        b_s_ready, b_m_valid, b_m_mode;
    logic [15:0] b_m_data;
`ifdef GRAY_SEQ_CHECK_EN
    logic        a_seq_err, b_seq_err;
`endif

    gray_conv_pipe #(.WIDTH(4), .STAGES(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid && !sel), .s_ready(a_s_ready), .s_data(s_data[3:0]), .s_mode(s_mode),
        .m_valid(a_m_valid), .m_ready(m_ready && !sel), .m_data(a_m_data), .m_mode(a_m_mode)
`ifdef GRAY_SEQ_CHECK_EN
        , .seq_err(a_seq_err)
`endif
    );

    gray_conv_pipe #(.WIDTH(16), .STAGES(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid && sel), .s_ready(b_s_ready), .s_data(s_data), .s_mode(s_mode),
        .m_valid(b_m_valid), .m_ready(m_ready && sel), .m_data(b_m_data), .m_mode(b_m_mode)
`ifdef GRAY_SEQ_CHECK_EN
        , .seq_err(b_seq_err)
`endif
    );

    logic        cur_s_ready, cur_m_valid, cur_m_mode, cur_seq_err;
    logic [15:0] cur_m_data;
    assign cur_s_ready = sel ? b_s_ready : a_s_ready;
    assign cur_m_valid = sel ? b_m_valid : a_m_valid;
    assign cur_m_mode  = sel ? b_m_mode  : a_m_mode;
    assign cur_m_data  = sel ? b_m_data  : {12'h000, a_m_data};
`ifdef GRAY_SEQ_CHECK_EN
    assign cur_seq_err = sel ? b_seq_err : a_seq_err;
`else
    assign cur_seq_err = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic        mode;
        logic [15:0] data;
        logic        err;
        int          acc;
    } exp_t;
    exp_t exp_q[$];

    logic [15:0] words_data [0:1023];
    logic        words_mode [0:1023];
    logic [15:0] out_data   [0:1023];

    logic [15:0] prev_g [0:1];
    logic        have_g [0:1];

    function automatic int width_of(input logic s);
        return s ? 16 : 4;
    endfunction

    function automatic int stages_of(input logic s);
        return s ? 3 : 2;
    endfunction

    // Binary value whose Gray code is g: XOR of all right shifts of g.
    function automatic logic [15:0] model_g2b(input logic [15:0] g, input int w);
        logic [15:0] r, m;
        m = 16'((32'd1 << w) - 1);
        g = g & m;
        r = '0;
        for (int i = 0; i < w; i++) r = r ^ (g >> i);
        return r & m;
    endfunction

    function automatic logic [15:0] model_b2g(input logic [15:0] b, input int w);
        logic [15:0] m;
        m = 16'((32'd1 << w) - 1);
        b = b & m;
        return (b ^ (b >> 1)) & m;
    endfunction

    task automatic clear_model();
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            prev_g[i] = '0;
            have_g[i] = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
    endtask

    // Drives n words from words_* into the selected DUT.
    // rdy_pat: 0 = m_ready always 1, 1 = random, 2 = held 0 for 5 cycles then 1.
    task automatic run_stream(input int n, input int rdy_pat, input int bound);
        int          sent = 0, got = 0, k = 0, early_acc = 0, first_out = -1;
        logic        hold = 1'b0, hold_m = 1'b0;
        logic [15:0] hold_d = '0;
        exp_t        e;
        int          w;
        w = width_of(sel);
        while (got < n && k < bound) begin
            @(negedge clk);
            s_valid = (sent < n);
            if (sent < n) begin
                s_data = words_data[sent];
                s_mode = words_mode[sent];
            end
            case (rdy_pat)
                0:       m_ready = 1'b1;
                1:       m_ready = ($urandom_range(0, 1) == 1);
                default: m_ready = (k >= 5);
            endcase
            #1;
            if (hold) begin
                checks++;
                if (!cur_m_valid || cur_m_data !== hold_d || cur_m_mode !== hold_m) begin
                    errors++;
                    $display("FAIL hold_stable cyc=%0d got v=%b d=%h m=%b want v=1 d=%h m=%b",
                             k, cur_m_valid, cur_m_data, cur_m_mode, hold_d, hold_m);
                end
            end
            if (rdy_pat == 2 && k >= 2 && k < 5) begin
                checks++;
                if (cur_s_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL full_s_ready cyc=%0d got %b want 0", k, cur_s_ready);
                end
            end
            if (cur_m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out cyc=%0d got %h want none", k, cur_m_data);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (cur_m_data !== e.data || cur_m_mode !== e.mode) begin
                        errors++;
                        $display("FAIL out_word idx=%0d got d=%h m=%b want d=%h m=%b",
                                 got, cur_m_data, cur_m_mode, e.data, e.mode);
                    end
`ifdef GRAY_SEQ_CHECK_EN
                    checks++;
                    if (cur_seq_err !== e.err) begin
                        errors++;
                        $display("FAIL seq_err idx=%0d got %b want %b", got, cur_seq_err, e.err);
                    end
`endif
                    if (rdy_pat == 0) begin
                        if (first_out < 0) first_out = k;
                        checks++;
                        if (k != e.acc + stages_of(sel) || k != first_out + got) begin
                            errors++;
                            $display("FAIL latency idx=%0d got cyc %0d want %0d", got, k, e.acc + stages_of(sel));
                        end
                    end
                    out_data[got] = cur_m_data;
                    got++;
                end
            end
            if (s_valid && cur_s_ready) begin
                e.mode = s_mode;
                e.data = s_mode ? model_b2g(s_data, w) : model_g2b(s_data, w);
                e.acc  = k;
                e.err  = 1'b0;
                if (!s_mode) begin
                    e.err = have_g[sel] && ($countones((s_data ^ prev_g[sel]) & 16'((32'd1 << w) - 1)) != 1);
                    prev_g[sel] = s_data & 16'((32'd1 << w) - 1);
                    have_g[sel] = 1'b1;
                end
                exp_q.push_back(e);
                if (k < 5) early_acc++;
                sent++;
            end
            hold   = cur_m_valid && !m_ready;
            hold_d = cur_m_data;
            hold_m = cur_m_mode;
            k++;
        end
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL stream_timeout got %0d words want %0d", got, n);
        end
        if (rdy_pat == 2) begin
            checks++;
            if (early_acc != stages_of(sel)) begin
                errors++;
                $display("FAIL stall_accepts got %0d want %0d", early_acc, stages_of(sel));
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        checks++;
        if (cur_m_valid !== 1'b0) begin
            errors++;
            $display("FAIL drained_valid got %b want 0", cur_m_valid);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if (a_m_valid !== 1'b0 || a_m_data !== 4'h0 || a_m_mode !== 1'b0 || a_s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_a got v=%b d=%h m=%b r=%b want 0 0 0 1", a_m_valid, a_m_data, a_m_mode, a_s_ready);
        end
        checks++;
        if (b_m_valid !== 1'b0 || b_m_data !== 16'h0 || b_m_mode !== 1'b0 || b_s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_b got v=%b d=%h m=%b r=%b want 0 0 0 1", b_m_valid, b_m_data, b_m_mode, b_s_ready);
        end
`ifdef GRAY_SEQ_CHECK_EN
        checks++;
        if (a_seq_err !== 1'b0 || b_seq_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_seq_err got %b%b want 00", a_seq_err, b_seq_err);
        end
`endif
    endtask

    task automatic test_first_word();
        sel = 1'b0;
        words_data[0] = 16'h000B; words_mode[0] = 1'b0;
        run_stream(1, 0, 20);
        checks++;
        if (out_data[0] !== 16'h000D) begin
            errors++;
            $display("FAIL g2b_1011 got %h want d", out_data[0]);
        end
    endtask

    task automatic test_b2g_word();
        sel = 1'b0;
        words_data[0] = 16'h000D; words_mode[0] = 1'b1;
        run_stream(1, 0, 20);
        checks++;
        if (out_data[0] !== 16'h000B) begin
            errors++;
            $display("FAIL b2g_1101 got %h want b", out_data[0]);
        end
    endtask

    task automatic test_exhaustive();
        logic [15:0] gray [0:15];
        sel = 1'b0;
        for (int i = 0; i < 32; i++) begin
            words_data[i] = 16'(i % 16);
            words_mode[i] = (i >= 16);
        end
        run_stream(32, 0, 100);
        for (int i = 0; i < 16; i++) gray[i] = out_data[16 + i];
        // Feed the DUT's own Gray output back through Gray-to-binary.
        for (int i = 0; i < 16; i++) begin
            words_data[i] = gray[i];
            words_mode[i] = 1'b0;
        end
        run_stream(16, 0, 60);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (out_data[i] !== 16'(i)) begin
                errors++;
                $display("FAIL round_trip idx=%0d got %h want %h", i, out_data[i], i);
            end
        end
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        for (int i = 0; i < 16; i++) begin
            words_data[i] = 16'($urandom_range(0, 15));
            words_mode[i] = ($urandom_range(0, 1) == 1);
        end
        run_stream(16, 0, 60);
    endtask

    task automatic test_stall();
        sel = 1'b0;
        for (int i = 0; i < 8; i++) begin
            words_data[i] = 16'($urandom_range(0, 15));
            words_mode[i] = i[0];
        end
        run_stream(8, 2, 60);
    endtask

    task automatic test_random_mixed();
        apply_reset();
        sel = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            words_data[i] = 16'($urandom_range(0, 65535));
            words_mode[i] = i[0];
        end
        run_stream(1000, 1, 10000);
    endtask

    task automatic test_reset_midstream();
        logic seen;
        apply_reset();
        sel = 1'b0;
        @(negedge clk);
        s_valid = 1'b1; s_mode = 1'b0; s_data = 16'h3; m_ready = 1'b0;
        @(negedge clk);
        s_data = 16'h5;
        @(negedge clk);
        s_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        #1;
        checks++;
        if (a_m_valid !== 1'b0 || a_s_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_valid got v=%b r=%b want v=0 r=1", a_m_valid, a_s_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            m_ready = 1'b1;
            #1;
            if (a_m_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midreset_leak got a flushed word want none");
        end
    endtask

    task automatic test_seq_err();
        apply_reset();
        sel = 1'b0;
        words_data[0] = 16'h0; words_mode[0] = 1'b0;
        words_data[1] = 16'h1; words_mode[1] = 1'b0;
        words_data[2] = 16'h9; words_mode[2] = 1'b1;
        words_data[3] = 16'h3; words_mode[3] = 1'b0;
        words_data[4] = 16'h0; words_mode[4] = 1'b0;
        run_stream(5, 0, 40);
        for (int i = 0; i < 40; i++) begin
            words_data[i] = 16'($urandom_range(0, 15));
            words_mode[i] = ($urandom_range(0, 3) == 0);
        end
        run_stream(40, 1, 400);
    endtask

    initial begin
        clear_model();
        test_reset();
        test_first_word();
        test_b2g_word();
        test_exhaustive();
        test_back_to_back();
        test_stall();
        test_reset_midstream();
        test_seq_err();
        test_random_mixed();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
